cpu_branch_unit: RTL and testbench

Program-counter and branch-resolution block that consumes the registered Carry, Zero and Borrow flags from `cpu_mreg`. Each enabled cycle it takes the decoded branch opcode and target address from the instruction decoder, evaluates the condition against the flags, and updates the program counter. It supports an optional hardware call/return stack and a halt state. It sits between `cpu_mreg` and the program-memory address input of the one-cycle CPU.

---
 rtl/cpu_branch_unit_if.sv | 15 +
 rtl/cpu_branch_unit.sv | 89 ++++++++
 tb/tb_cpu_branch_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/cpu_branch_unit_if.sv
// cpu_branch_unit_if: decoder/flag side of the branch unit grouped with its PC and status outputs
interface cpu_branch_unit_if #(parameter int ADDR_W = 8);
   logic              EN;
   logic [3:0]        OP;
   logic [ADDR_W-1:0] TARGET;
   logic              C;
   logic              Z;
   logic              B;
   logic [ADDR_W-1:0] PC;
   logic              TAKEN;
   logic              HALTED;
   logic              STACK_ERR;
   modport master (output EN, OP, TARGET, C, Z, B, input PC, TAKEN, HALTED, STACK_ERR);
   modport slave (input EN, OP, TARGET, C, Z, B, output PC, TAKEN, HALTED, STACK_ERR);
endinterface

// File: rtl/cpu_branch_unit.sv
// cpu_branch_unit: PC update, flag-conditioned branches, halt state; return stack under CPU_BRANCH_STACK_EN
module cpu_branch_unit #(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4
) (
   input logic               CLK,
   input logic               RST,
   cpu_branch_unit_if.slave  bus
);
   typedef enum logic {RUN, HALT} state_t;
   localparam logic [3:0] OP_HLT = 4'd10;
   state_t            state;
   logic              adv;
   logic              cond;
   logic              jump;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] dest;
`ifdef CPU_BRANCH_STACK_EN
   localparam logic [3:0] OP_CALL = 4'd8;
   localparam logic [3:0] OP_RET  = 4'd9;
   localparam int SP_W = $clog2(STACK_DEPTH + 1);
   localparam int IX_W = $clog2(STACK_DEPTH);
   logic [ADDR_W-1:0] stk [STACK_DEPTH];
   logic [SP_W-1:0]   sp;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              serr;
`endif
   always_comb begin
      adv    = state == RUN && bus.EN;
      pc_inc = bus.PC + ADDR_W'(1);
      case (bus.OP)
         4'd1:    cond = 1'b1;
         4'd2:    cond = bus.C;
         4'd3:    cond = !bus.C;
         4'd4:    cond = bus.Z;
         4'd5:    cond = !bus.Z;
         4'd6:    cond = bus.B;
         4'd7:    cond = !bus.B;
         default: cond = 1'b0;
      endcase
`ifdef CPU_BRANCH_STACK_EN
      full  = sp == SP_W'(STACK_DEPTH);
      empty = sp == '0;
      push  = bus.OP == OP_CALL && !full;
      pop   = bus.OP == OP_RET && !empty;
      serr  = (bus.OP == OP_CALL && full) || (bus.OP == OP_RET && empty);
      jump  = cond || push || pop;
      dest  = pop ? stk[IX_W'(sp - SP_W'(1))] : bus.TARGET;
`else
      jump  = cond;
      dest  = bus.TARGET;
`endif
   end
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state      <= RUN;
         bus.PC     <= '0;
         bus.TAKEN  <= 1'b0;
         bus.HALTED <= 1'b0;
`ifdef CPU_BRANCH_STACK_EN
         bus.STACK_ERR <= 1'b0;
         sp            <= '0;
`endif
      end else if (adv) begin
         bus.TAKEN <= jump;
         bus.PC    <= jump ? dest : bus.OP == OP_HLT ? bus.PC : pc_inc;
         if (bus.OP == OP_HLT) begin
            state      <= HALT;
            bus.HALTED <= 1'b1;
         end
`ifdef CPU_BRANCH_STACK_EN
         bus.STACK_ERR <= bus.STACK_ERR | serr;
         sp            <= push ? sp + SP_W'(1) : pop ? sp - SP_W'(1) : sp;
`endif
      end else begin
         bus.TAKEN <= 1'b0;
      end
   end
`ifdef CPU_BRANCH_STACK_EN
   always_ff @(posedge CLK) begin
      if (RST && adv && push) stk[IX_W'(sp)] <= pc_inc;
   end
`else
   assign bus.STACK_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_branch_unit.sv
// tb_cpu_branch_unit: directed steps with a queue of expected PC/status per clock
module tb_cpu_branch_unit;
   typedef struct packed {
      logic [7:0] pc;
      logic       taken;
      logic       halted;
      logic       serr;
   } exp_t;
`ifdef CPU_BRANCH_STACK_EN
   localparam logic SE = 1'b1;
`else
   localparam logic SE = 1'b0;
`endif
   logic CLK = 1'b0;
   logic RST = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t q[$];
   cpu_branch_unit_if #(.ADDR_W(8)) bus ();
   cpu_branch_unit #(.ADDR_W(8), .STACK_DEPTH(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step(input logic rst, input logic en, input logic [3:0] op, input logic [7:0] tgt,
                       input logic c, input logic z, input logic b,
                       input logic [7:0] epc, input logic et, input logic eh, input logic es,
                       input string tag);
      exp_t e;
      RST = rst; bus.EN = en; bus.OP = op; bus.TARGET = tgt;
      bus.C = c; bus.Z = z; bus.B = b;
      q.push_back('{pc: epc, taken: et, halted: eh, serr: es});
      @(posedge CLK);
      #1;
      e = q.pop_front();
      chk({tag, ".pc"}, bus.PC, e.pc);
      chk({tag, ".taken"}, {7'd0, bus.TAKEN}, {7'd0, e.taken});
      chk({tag, ".halted"}, {7'd0, bus.HALTED}, {7'd0, e.halted});
      chk({tag, ".serr"}, {7'd0, bus.STACK_ERR}, {7'd0, e.serr});
   endtask
   initial begin
      bus.EN = 1'b0; bus.OP = 4'd0; bus.TARGET = 8'd0; bus.C = 1'b0; bus.Z = 1'b0; bus.B = 1'b0;
      step(0, 1, 4'd1, 8'h77, 0, 0, 0, 8'h00, 0, 0, 0, "reset0");
      step(0, 1, 4'd1, 8'h77, 0, 0, 0, 8'h00, 0, 0, 0, "reset1");
      for (int i = 1; i <= 5; i++)
         step(1, 1, 4'd0, 8'h99, 0, 0, 0, 8'(i), 0, 0, 0, "nop_seq");
      step(1, 1, 4'd2, 8'h40, 1, 0, 0, 8'h40, 1, 0, 0, "jc_t");
      step(1, 1, 4'd4, 8'h80, 1, 0, 0, 8'h41, 0, 0, 0, "jz_f");
      step(1, 1, 4'd3, 8'h90, 1, 0, 0, 8'h42, 0, 0, 0, "jnc_f");
      step(1, 1, 4'd3, 8'h50, 0, 0, 0, 8'h50, 1, 0, 0, "jnc_t");
      step(1, 1, 4'd2, 8'h90, 0, 1, 1, 8'h51, 0, 0, 0, "jc_f");
      step(1, 1, 4'd4, 8'h60, 0, 1, 0, 8'h60, 1, 0, 0, "jz_t");
      step(1, 1, 4'd5, 8'h90, 0, 1, 0, 8'h61, 0, 0, 0, "jnz_f");
      step(1, 1, 4'd5, 8'h70, 1, 0, 1, 8'h70, 1, 0, 0, "jnz_t");
      step(1, 1, 4'd6, 8'h90, 1, 1, 0, 8'h71, 0, 0, 0, "jb_f");
      step(1, 1, 4'd6, 8'h30, 0, 0, 1, 8'h30, 1, 0, 0, "jb_t");
      step(1, 1, 4'd7, 8'h90, 0, 0, 1, 8'h31, 0, 0, 0, "jnb_f");
      step(1, 1, 4'd7, 8'h04, 1, 1, 0, 8'h04, 1, 0, 0, "jnb_t");
      step(1, 1, 4'd11, 8'h90, 1, 1, 1, 8'h05, 0, 0, 0, "op11_nop");
`ifdef CPU_BRANCH_STACK_EN
      step(1, 1, 4'd8, 8'h10, 0, 0, 0, 8'h10, 1, 0, 0, "call");
      step(1, 1, 4'd9, 8'h00, 0, 0, 0, 8'h06, 1, 0, 0, "ret");
      step(1, 1, 4'd8, 8'h20, 0, 0, 0, 8'h20, 1, 0, 0, "call1");
      step(1, 1, 4'd8, 8'h30, 0, 0, 0, 8'h30, 1, 0, 0, "call2");
      step(1, 1, 4'd8, 8'h40, 0, 0, 0, 8'h40, 1, 0, 0, "call3");
      step(1, 1, 4'd8, 8'h50, 0, 0, 0, 8'h50, 1, 0, 0, "call4");
      step(1, 1, 4'd8, 8'h60, 0, 0, 0, 8'h51, 0, 0, 1, "call_full");
      step(1, 1, 4'd9, 8'h00, 0, 0, 0, 8'h41, 1, 0, 1, "ret4");
      step(1, 1, 4'd9, 8'h00, 0, 0, 0, 8'h31, 1, 0, 1, "ret3");
      step(1, 1, 4'd9, 8'h00, 0, 0, 0, 8'h21, 1, 0, 1, "ret2");
      step(1, 1, 4'd9, 8'h00, 0, 0, 0, 8'h07, 1, 0, 1, "ret1");
      step(1, 1, 4'd9, 8'h00, 0, 0, 0, 8'h08, 0, 0, 1, "ret_empty");
`else
      step(1, 1, 4'd8, 8'h10, 0, 0, 0, 8'h06, 0, 0, 0, "call_nop");
      step(1, 1, 4'd9, 8'h10, 0, 0, 0, 8'h07, 0, 0, 0, "ret_nop");
`endif
      step(1, 1, 4'd1, 8'hFF, 0, 0, 0, 8'hFF, 1, 0, SE, "jmp_ff");
      step(1, 1, 4'd0, 8'h12, 0, 0, 0, 8'h00, 0, 0, SE, "wrap");
      for (int i = 0; i < 3; i++)
         step(1, 0, 4'd1, 8'h55, 1, 1, 1, 8'h00, 0, 0, SE, "en_off");
      step(1, 1, 4'd1, 8'h33, 0, 0, 0, 8'h33, 1, 0, SE, "jmp_33");
      step(1, 0, 4'd1, 8'h44, 0, 0, 0, 8'h33, 0, 0, SE, "taken_clr");
      step(1, 0, 4'd10, 8'h44, 0, 0, 0, 8'h33, 0, 0, SE, "hlt_en_off");
      step(1, 1, 4'd1, 8'h20, 0, 0, 0, 8'h20, 1, 0, SE, "jmp_20");
      step(1, 1, 4'd10, 8'h00, 0, 0, 0, 8'h20, 0, 1, SE, "hlt");
      for (int i = 0; i < 10; i++)
         step(1, i[0], 4'd1, 8'h99, 1, 1, 1, 8'h20, 0, 1, SE, "halted");
      step(0, 1, 4'd1, 8'h99, 0, 0, 0, 8'h00, 0, 0, 0, "reset_halt");
      step(1, 1, 4'd0, 8'h00, 0, 0, 0, 8'h01, 0, 0, 0, "post_reset");
      step(1, 1, 4'd9, 8'h00, 0, 0, 0, 8'h02, 0, 0, SE, "stack_empty");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
